instr_fetch_queue: RTL
======================

Name: instr_fetch_queue

Overview:
Parametrised instruction front end that replaces the bare PC-plus-stall path of the single-cycle core. It issues sequential fetches to a synchronous-read instruction memory and buffers returned words in a DEPTH-entry queue. It hands each word, tagged with its PC, to decode over a valid/ready handshake. It supports branch redirect with flush, and a halt/drain sequence that produces done.

Parameters:
D, 12, PC / instruction-address width
IW, 9, instruction word width
DEPTH, 4, queue entries; power of two, minimum 2

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request this cycle
imem_addr  output  D  fetch address (current fetch PC)
imem_rdata  input  IW  instruction word; valid exactly one cycle after imem_req
redirect_en  input  1  branch/jump taken; redirect fetch
redirect_target  input  D  new fetch PC
halt  input  1  stop fetching (program end reached)
out_valid  output  1  head entry valid
out_ready  input  1  decode accepts head
out_instr  output  IW  head instruction
out_pc  output  D  PC of head instruction
count  output  $clog2(DEPTH)+1  occupied entries
done  output  1  halted and fully drained

Behaviour:
- Reset (reset=0, async) values:
  - fpc=0, queue empty, count=0, in-flight flag=0.
  - imem_req=0, imem_addr=0, out_valid=0, out_instr=0, out_pc=0, done=0.
  - Halt latch cleared.
  - Reset mid-operation discards all queued and in-flight words.
- Issue rule:
  - imem_req=1 when: not halted, not redirect_en, and count + inflight (+1 if a pop occurs this cycle is NOT credited) < DEPTH.
  - Pop-this-cycle is not credited, to keep the timing path short.
  - On issue: inflight<=1, pc_tag<=fpc, fpc<=fpc+1 (modulo 2^D; 2^D-1 wraps to 0).
- Response: the cycle after an issue, if inflight=1 and no redirect this cycle, push {imem_rdata, pc_tag} into the queue.
- Pop: when out_valid && out_ready, advance the head.
- Simultaneous push and pop: both occur; count unchanged.
- Full queue: never pushed, because issue is blocked by the credit rule.
- Empty queue: out_valid=0; out_instr/out_pc hold their last values (don't-care).
- Redirect (redirect_en=1):
  - Same edge: queue flushed (count<=0), inflight<=0, any response arriving this cycle discarded, fpc<=redirect_target, imem_req=0.
  - Next cycle: issue at the target.
  - Redirect overrides pop and push in the same cycle.
- Halt:
  - halt=1 sets a sticky latch; no further issues. A redirect while halted updates fpc but does not issue.
  - An in-flight response still pushes. The queue keeps draining.
  - done=1 (registered) once latch=1 && count=0 && inflight=0. Sticky until reset.
- Latency, sequential path: req at cycle N, rdata at N+1, written at the end of N+1, out_valid at N+2.
- Throughput: one instruction per cycle when DEPTH>=3 and out_ready held high.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the queue is empty (or just emptied by a pop) and a response arrives, the word is driven combinationally on out_instr/out_pc with out_valid=1 in cycle N+1.
  - If out_ready=1, it is consumed without being written.
  - Otherwise it is written normally.
- Not defined: no bypass; latency is as stated above.

Decomposition:
- Package fetch_pkg holds:
  - typedef fetch_entry_t {logic [IW-1:0] instr; logic [D-1:0] pc;}, parametrised via localparams matching the defaults.
  - localparam PTR_W = $clog2(DEPTH).
- Sub-module fetch_fifo (DEPTH x entry, wr/rd/flush ports, count output, circular pointers with an extra wrap bit) is instantiated once.
- The issue/redirect/halt logic lives in instr_fetch_queue.

Test Plan:
- Reset release, out_ready=1, ROM returns addr as data:
  - imem_addr 0,1,2,… on consecutive cycles.
  - out_valid first high at cycle 2 with out_pc=0, out_instr=0.
  - Then one instruction per cycle.
- out_ready=0 for 10 cycles:
  - count saturates at 4; exactly 4 requests issued, imem_req then 0.
  - After out_ready=1, PCs 0..3 emerge in order and fetch resumes at 4.
- Queue holding PCs 5..7, redirect_en with target=0x40:
  - Next cycle count=0, out_valid=0, response for PC 8 dropped.
  - imem_addr=0x40 the cycle after; first out_pc=0x40.
- fpc=0xFFE, free-running: out_pc sequence 0xFFE, 0xFFF, 0x000.
- halt asserted with 3 queued and 1 in flight, out_ready=1: no new imem_req; 4 instructions delivered; done=1 the cycle after the last pop and stays 1.
- Async reset pulse mid-stream (count=3): outputs clear immediately without a clock edge; after release, fetch restarts at PC 0.
- FETCH_BYPASS_EN: in the first test, out_valid rises at cycle 1.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch front end.
//
// Contents:
//   FETCH_D / FETCH_IW / FETCH_DEPTH : default PC width, instruction width, queue depth
//   PTR_W                            : queue index width, $clog2(FETCH_DEPTH)
//   fetch_entry_t                    : one queued word, {instr, pc}
//
// Optional feature macro used elsewhere in this slice: FETCH_BYPASS_EN.
package fetch_pkg;

    localparam int FETCH_D     = 12;
    localparam int FETCH_IW    = 9;
    localparam int FETCH_DEPTH = 4;
    localparam int PTR_W       = $clog2(FETCH_DEPTH);

    // Instruction word tagged with the PC it was fetched from.
    typedef struct packed {
        logic [FETCH_IW-1:0] instr;
        logic [FETCH_D-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if: bundle of every non-clock signal of the fetch front end.
//
// Signals:
//   imem_req, imem_addr   fetch request and address toward instruction memory
//   imem_rdata            word returned exactly one cycle after imem_req
//   redirect_en/_target   taken branch/jump and its new fetch PC
//   halt                  stop fetching (program end)
//   out_valid/out_ready   decode handshake; out_instr/out_pc carry the head entry
//   count                 occupied queue entries
//   done                  halted and fully drained
//
// Modports: master = fetch unit, slave = memory/decode/control side.
//
// Handshake: a word moves to decode on every rising edge where out_valid and
// out_ready are both 1. out_valid never depends on out_ready; out_instr/out_pc
// are stable while out_valid=1 and out_ready=0 (absent a redirect, which
// flushes the queue and drops the offered word).
interface instr_fetch_queue_if
    import fetch_pkg::*;
#(
    parameter int D     = FETCH_D,
    parameter int IW    = FETCH_IW,
    parameter int DEPTH = FETCH_DEPTH
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          imem_req;
    logic [D-1:0]  imem_addr;
    logic [IW-1:0] imem_rdata;
    logic          redirect_en;
    logic [D-1:0]  redirect_target;
    logic          halt;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_instr;
    logic [D-1:0]  out_pc;
    logic [CW-1:0] count;
    logic          done;

    modport master (
        output imem_req, imem_addr, out_valid, out_instr, out_pc, count, done,
        input  imem_rdata, redirect_en, redirect_target, halt, out_ready
    );

    modport slave (
        input  imem_req, imem_addr, out_valid, out_instr, out_pc, count, done,
        output imem_rdata, redirect_en, redirect_target, halt, out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: circular queue of 2**AW entries with an extra wrap bit on each
// pointer, so full (count = 2**AW) and empty (count = 0) are distinguishable.
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-low reset
//   flush        empty the queue this edge; wins over wr and rd
//   wr, wr_data  write one entry at the tail (caller never writes when full)
//   rd           advance the head (caller never reads when empty)
//   rd_data      head entry; holds a stale value while empty
//   count        occupied entries, AW+1 bits
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int WIDTH = $bits(fetch_entry_t),
    parameter int AW    = PTR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count
);
    localparam int DEPTH = 1 << AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    // Storage is reset too, so the head output reads zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + (AW+1)'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = wr_ptr - rd_ptr;

endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: sequential instruction fetch front end. Issues one fetch
// per cycle to a synchronous-read instruction memory while queue credit
// remains, buffers returned words tagged with their PC, and offers them to
// decode over out_valid/out_ready. Supports redirect-with-flush and a sticky
// halt that drains the queue and then raises done.
//
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    instr_fetch_queue_if.master (imem_*, redirect_*, halt, out_*, count, done)
//
// Optional feature: define FETCH_BYPASS_EN to forward a returning word straight
// to decode in the cycle it arrives when the queue is empty.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int D     = FETCH_D,
    parameter int IW    = FETCH_IW,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    instr_fetch_queue_if.master   bus
);
    localparam int            AW      = $clog2(DEPTH);
    localparam int            CW      = AW + 1;
    localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);

    logic [D-1:0]  fpc;
    logic [D-1:0]  pc_tag;
    logic          inflight;
    logic          halt_q;
    logic          done_q;

    logic [CW-1:0] fifo_count;
    logic          fifo_valid;
    fetch_entry_t  head;
    fetch_entry_t  wr_entry;

    logic          halted;
    logic [CW:0]   credit_used;
    logic          issue;
    logic          resp;
    logic          bypass;
    logic          fifo_wr;
    logic          fifo_rd;
    logic [CW-1:0] count_next;

    always_comb begin
        halted      = halt_q | bus.halt;
        // A pop in this same cycle is deliberately not credited: the issue
        // decision then depends only on registered state plus redirect/halt.
        credit_used = {1'b0, fifo_count} + {{CW{1'b0}}, inflight};
        // Gated by reset so no request leaves while reset is held.
        issue       = reset & ~halted & ~bus.redirect_en & (credit_used < DEPTH_C);
        // A response arriving under a redirect belongs to the old path.
        resp        = inflight & ~bus.redirect_en;
        fifo_valid  = (fifo_count != '0);

        wr_entry.instr = bus.imem_rdata;
        wr_entry.pc    = pc_tag;

`ifdef FETCH_BYPASS_EN
        bypass = resp & ~fifo_valid;
`else
        bypass = 1'b0;
`endif
        // A bypassed word taken by decode this cycle is never stored.
        fifo_wr    = resp & ~(bypass & bus.out_ready);
        fifo_rd    = fifo_valid & bus.out_ready & ~bus.redirect_en;
        count_next = bus.redirect_en ? '0
                   : fifo_count + CW'(fifo_wr) - CW'(fifo_rd);
    end

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush   (bus.redirect_en),
        .wr      (fifo_wr),
        .wr_data (wr_entry),
        .rd      (fifo_rd),
        .rd_data (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc      <= '0;
            pc_tag   <= '0;
            inflight <= 1'b0;
            halt_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            halt_q <= halted;
            // While halted nothing issues, so the next in-flight flag is 0 and
            // done only waits for the queue to empty. Using the next-state
            // count makes done rise in the first cycle the queue is empty.
            done_q <= done_q | (halted & (count_next == '0));
            if (bus.redirect_en) begin
                fpc      <= bus.redirect_target;
                inflight <= 1'b0;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc_tag <= fpc;
                    fpc    <= fpc + D'(1);
                end
            end
        end
    end

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fpc;
    assign bus.out_valid = fifo_valid | bypass;
    assign bus.out_instr = bypass ? bus.imem_rdata : head.instr;
    assign bus.out_pc    = bypass ? pc_tag         : head.pc;
    assign bus.count     = fifo_count;
    assign bus.done      = done_q;

endmodule
